// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle phase controller.
//   state_t  : phase encodings presented on State (IF/ID/EXE/WB/MEM/HALT/ERR)
//   CLS_*    : opcode class patterns matched against the top opcode bits
//   CNT_W    : width of the optional performance counters
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE    = 3'b010,
    ST_WB     = 3'b011,
    ST_MEM    = 3'b100,
    ST_HALT   = 3'b101,
    ST_ERR    = 3'b110,
    ST_UNUSED = 3'b111
  } state_t;

  localparam logic [2:0]  CLS_J = 3'b111;
  localparam logic [3:0]  CLS_B = 4'b1101;
  localparam logic [3:0]  CLS_M = 4'b1100;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/mc_phase_ctrl_if.sv
// Handshake bundle between the instruction/memory side and the phase controller.
//   Op, Stall, MemReady       : driven by master, sampled by the controller
//   State, InstrDone, Halted,
//   Timeout                   : driven by the controller (slave)
interface mc_phase_ctrl_if #(
  parameter int unsigned OP_W = 6
);
  import mc_ctrl_pkg::*;

  logic [OP_W-1:0] Op;
  logic            Stall;
  logic            MemReady;
  state_t          State;
  logic            InstrDone;
  logic            Halted;
  logic            Timeout;

  modport master (
    output Op, Stall, MemReady,
    input  State, InstrDone, Halted, Timeout
  );

  modport slave (
    input  Op, Stall, MemReady,
    output State, InstrDone, Halted, Timeout
  );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory-wait timer for the phase controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   hold       : freeze the count this cycle (highest priority)
//   clear      : zero the count
//   count      : increment the count (one more wait cycle)
//   expire     : combinational, this increment would reach MAX
// MAX = 0 disables expiry and the counter stays at zero.
module mc_wait_timer #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam logic [W-1:0] LAST = (MAX > 0) ? W'(MAX - 1) : '0;

  logic [W-1:0] cnt;

  assign expire = (MAX != 0) && count && !hold && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!hold) begin
      if (clear || expire || (MAX == 0)) begin
        cnt <= '0;
      end else if (count) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_phase_ctrl.sv
// Multicycle phase sequencer: steps IF/ID/EXE/MEM/WB per opcode class, with
// memory-ready handshake, global stall, HALT opcode, memory-wait timeout into
// a sticky ERR state and an instruction-retire pulse.
//   CLK      : clock, rising edge
//   RST      : asynchronous reset, active-low
//   bus      : mc_phase_ctrl_if.slave (Op, Stall, MemReady in; State,
//              InstrDone, Halted, Timeout out)
//   CycleCnt : (MC_PERF_CNT_EN only) non-reset cycles, frozen in HALT/ERR
//   InstrCnt : (MC_PERF_CNT_EN only) retired instructions
// Optional feature macro: MC_PERF_CNT_EN.
module mc_phase_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned     OP_W        = 6,
  parameter logic [OP_W-1:0] HALT_OP     = 6'h3F,
  parameter int unsigned     MEM_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  mc_phase_ctrl_if.slave     bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   CycleCnt,
  output logic [CNT_W-1:0]   InstrCnt
`endif
);

  logic [3:0] top4;
  logic       is_halt, is_j, is_b, is_m, is_load;
  logic       waiting, expire, retire;
  state_t     st_nxt;

  assign top4    = bus.Op[OP_W-1 -: 4];
  assign is_halt = (bus.Op == HALT_OP);
  assign is_j    = (top4[3:1] == CLS_J) && !is_halt;
  assign is_b    = (top4 == CLS_B);
  assign is_m    = (top4 == CLS_M);
  assign is_load = is_m && bus.Op[0];

  // Only IF and MEM wait on memory; every other cycle clears the timer.
  assign waiting = ((bus.State == ST_IF) || (bus.State == ST_MEM)) && !bus.MemReady;

  mc_wait_timer #(
    .MAX(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk   (CLK),
    .rst_n (RST),
    .hold  (bus.Stall),
    .clear (!waiting),
    .count (waiting),
    .expire(expire)
  );

  always_comb begin
    st_nxt = bus.State;
    unique case (bus.State)
      ST_IF: begin
        if (bus.MemReady)  st_nxt = ST_ID;
        else if (expire)   st_nxt = ST_ERR;
      end
      ST_ID: begin
        if (is_halt)       st_nxt = ST_HALT;
        else if (is_j)     st_nxt = ST_IF;
        else               st_nxt = ST_EXE;
      end
      ST_EXE: begin
        if (is_b)          st_nxt = ST_IF;
        else if (is_m)     st_nxt = ST_MEM;
        else               st_nxt = ST_WB;
      end
      ST_MEM: begin
        if (!bus.MemReady) st_nxt = expire ? ST_ERR : ST_MEM;
        else if (is_load)  st_nxt = ST_WB;
        else               st_nxt = ST_IF;
      end
      ST_WB:               st_nxt = ST_IF;
      ST_HALT, ST_ERR:     st_nxt = bus.State;
      default:             st_nxt = ST_IF;
    endcase
  end

  assign retire = (st_nxt == ST_IF) &&
                  ((bus.State == ST_ID) || (bus.State == ST_EXE) ||
                   (bus.State == ST_MEM) || (bus.State == ST_WB));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.State     <= ST_IF;
      bus.InstrDone <= 1'b0;
      bus.Halted    <= 1'b0;
      bus.Timeout   <= 1'b0;
    end else if (bus.Stall) begin
      bus.InstrDone <= 1'b0;
    end else begin
      bus.State     <= st_nxt;
      bus.InstrDone <= retire;
      bus.Halted    <= (st_nxt == ST_HALT);
      bus.Timeout   <= (st_nxt == ST_ERR);
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if ((bus.State != ST_HALT) && (bus.State != ST_ERR)) CycleCnt <= CycleCnt + 1'b1;
      if (!bus.Stall && retire)                             InstrCnt <= InstrCnt + 1'b1;
    end
  end
`endif

endmodule
